// File: rtl/systolic_result_drain.sv
// Result drain for the systolic MAC array: snapshots the accumulator matrix on
// compute_done rising, requantises it and streams one row per valid/ready beat.
module systolic_result_drain #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int OP_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           compute_done,
  input  logic [ROWS*COLS*OP_WIDTH-1:0]  output_matrix,
  input  logic [SHIFT_WIDTH-1:0]         shift_amt,
  input  logic                           clr_flags,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COLS*OUT_WIDTH-1:0]      out_data,
  output logic [$clog2(ROWS)-1:0]        out_row,
  output logic                           out_last,
  output logic                           out_sat,
  output logic                           busy,
  output logic                           drain_done,
  output logic                           overrun,
  output logic [15:0]                    frame_count
);

  localparam int ROW_W    = $clog2(ROWS);
  localparam int ROW_BITS = COLS * OP_WIDTH;
  localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [OUT_WIDTH-1:0] SAT_MAX  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN  = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   done_prev_q, done_prev_d;
  logic [ROW_BITS-1:0]    snap_q [ROWS];
  logic [ROW_BITS-1:0]    snap_d [ROWS];
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [ROW_W-1:0]       row_idx_q, row_idx_d;
  logic                   drain_done_q, drain_done_d;
  logic                   overrun_q, overrun_d;
  logic [15:0]            frame_count_q, frame_count_d;

  logic                   rise;
  logic                   xfer;
  logic                   capture;
  logic [ROW_BITS-1:0]    in_rows [ROWS];
  logic [ROW_BITS-1:0]    cur_row;
  logic [COLS-1:0]        elem_sat;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_in_rows
    assign in_rows[gi] = output_matrix[gi*ROW_BITS +: ROW_BITS];
  end

  assign rise = compute_done & ~done_prev_q;
  assign xfer = (state_q == STREAM) & out_ready;

  always_comb begin
    state_d       = state_q;
    done_prev_d   = compute_done;
    snap_d        = snap_q;
    shift_d       = shift_q;
    row_idx_d     = row_idx_q;
    drain_done_d  = 1'b0;
    overrun_d     = clr_flags ? 1'b0 : overrun_q;
    frame_count_d = frame_count_q;
    capture       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          capture = 1'b1;
        end
      end
      STREAM: begin
        if (xfer && (row_idx_q == LAST_ROW)) begin
          drain_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          // A new frame arriving exactly as the old one finishes is taken without a bubble.
          if (rise) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            row_idx_d = row_idx_q + ROW_W'(1);
          end
          if (rise) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d   = STREAM;
      row_idx_d = '0;
      shift_d   = shift_amt;
      snap_d    = in_rows;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      done_prev_q   <= 1'b0;
      shift_q       <= '0;
      row_idx_q     <= '0;
      drain_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
      for (int r = 0; r < ROWS; r++) begin
        snap_q[r] <= '0;
      end
    end else begin
      state_q       <= state_d;
      done_prev_q   <= done_prev_d;
      shift_q       <= shift_d;
      row_idx_q     <= row_idx_d;
      drain_done_q  <= drain_done_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      snap_q        <= snap_d;
    end
  end

  assign cur_row = snap_q[row_idx_q];

  // Arithmetic shift by >= OP_WIDTH fills with the sign bit, giving 0 or -1.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_requant
    logic signed [OP_WIDTH-1:0]    elem;
    logic signed [OP_WIDTH-1:0]    shifted;
    logic [OP_WIDTH-OUT_WIDTH:0]   hi;

    assign elem          = cur_row[gi*OP_WIDTH +: OP_WIDTH];
    assign shifted       = elem >>> shift_q;
    assign hi            = shifted[OP_WIDTH-1:OUT_WIDTH-1];
    assign elem_sat[gi]  = (|hi) & ~(&hi);
    assign out_data[gi*OUT_WIDTH +: OUT_WIDTH] =
      elem_sat[gi] ? (shifted[OP_WIDTH-1] ? SAT_MIN : SAT_MAX) : shifted[OUT_WIDTH-1:0];
  end

  assign busy        = (state_q == STREAM);
  assign out_valid   = busy;
  assign out_row     = row_idx_q;
  assign out_last    = busy & (row_idx_q == LAST_ROW);
  assign out_sat     = busy & (|elem_sat);
  assign drain_done  = drain_done_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: expected row beats are queued on
// capture and compared as each beat transfers.
module tb_systolic_result_drain;

  logic          clk = 1'b0;
  logic          rst;
  logic          compute_done;
  logic [2047:0] output_matrix;
  logic [4:0]    shift_amt;
  logic          clr_flags;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic [2:0]    out_row;
  logic          out_last;
  logic          out_sat;
  logic          busy;
  logic          drain_done;
  logic          overrun;
  logic [15:0]   frame_count;

  typedef struct packed {
    logic [127:0] data;
    logic [2:0]   row;
    logic         last;
    logic         sat;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int xfer_count = 0;
  int exp_frames = 0;
  logic [2047:0] mat_seq, mat_a, mat_b, mat_sat;

  always #5 clk = ~clk;

  systolic_result_drain dut (
    .clk(clk), .rst(rst), .compute_done(compute_done), .output_matrix(output_matrix),
    .shift_amt(shift_amt), .clr_flags(clr_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .out_sat(out_sat), .busy(busy), .drain_done(drain_done), .overrun(overrun),
    .frame_count(frame_count)
  );

  function automatic void requant(input logic [31:0] e, input int sh,
                                  output logic [15:0] o, output logic s);
    longint v;
    v = longint'($signed(e));
    v = v >>> sh;
    if (v > 32767) begin
      o = 16'h7FFF; s = 1'b1;
    end else if (v < -32768) begin
      o = 16'h8000; s = 1'b1;
    end else begin
      o = v[15:0]; s = 1'b0;
    end
  endfunction

  task automatic push_frame(input logic [2047:0] m, input int sh);
    beat_t b;
    logic [15:0] o;
    logic s;
    for (int r = 0; r < 8; r++) begin
      b.data = '0; b.sat = 1'b0;
      for (int j = 0; j < 8; j++) begin
        requant(m[(r*8+j)*32 +: 32], sh, o, s);
        b.data[j*16 +: 16] = o;
        b.sat = b.sat | s;
      end
      b.row  = r[2:0];
      b.last = (r == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise compute_done for one cycle; queue the frame when it is expected to be captured.
  task automatic fire(input logic [2047:0] m, input int sh, input bit expect_capture);
    output_matrix = m;
    shift_amt     = sh[4:0];
    compute_done  = 1'b1;
    if (expect_capture) push_frame(m, sh);
    step();
    compute_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      beat_t b;
      checks++;
      xfer_count++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got row=%0d data=%h", out_row, out_data);
      end else begin
        b = exp_q.pop_front();
        if (out_data !== b.data || out_row !== b.row || out_last !== b.last || out_sat !== b.sat) begin
          failures++;
          $display("FAIL beat got row=%0d last=%b sat=%b data=%h want row=%0d last=%b sat=%b data=%h",
                   out_row, out_last, out_sat, out_data, b.row, b.last, b.sat, b.data);
        end else begin
          $display("beat row=%0d last=%b sat=%b data=%h", out_row, out_last, out_sat, out_data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; compute_done = 1'b0; output_matrix = '0; shift_amt = '0;
    clr_flags = 1'b0; out_ready = 1'b0;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_sat !== 1'b0 ||
        drain_done !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got valid=%b busy=%b last=%b sat=%b dd=%b ovr=%b want all 0",
               out_valid, busy, out_last, out_sat, drain_done, overrun);
    end
    checks++;
    if (out_row !== 3'd0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts got row=%0d frames=%0d want 0 0", out_row, frame_count);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int x0, dd;
    x0 = xfer_count; dd = 0;
    out_ready = 1'b1;
    fire(mat_seq, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_row !== 3'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency got valid=%b row=%0d busy=%b want 1 0 1", out_valid, out_row, busy);
    end
    checks++;
    if (out_data[127:112] !== 16'd7) begin
      failures++;
      $display("FAIL basic_elem07 got %h want 0007", out_data[127:112]);
    end
    for (int c = 0; c < 9; c++) begin
      step();
      if (drain_done) dd++;
    end
    exp_frames++;
    checks++;
    if (dd != 1 || frame_count !== exp_frames[15:0] || xfer_count - x0 != 8 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_end got dd=%0d frames=%0d xfers=%0d valid=%b want 1 %0d 8 0",
               dd, frame_count, xfer_count - x0, out_valid, exp_frames);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int x0;
    bit done;
    pat = 4'b1001;
    x0 = xfer_count; done = 0;
    out_ready = 1'b1;
    fire(mat_a, 8, 1);
    for (int c = 0; c < 100 && !done; c++) begin
      out_ready = pat[c % 4];
      if (out_valid && !out_ready && exp_q.size() > 0) begin
        checks++;
        if (out_data !== exp_q[0].data || out_row !== exp_q[0].row) begin
          failures++;
          $display("FAIL stall_hold got row=%0d data=%h want row=%0d data=%h",
                   out_row, out_data, exp_q[0].row, exp_q[0].data);
        end
      end
      step();
      if (drain_done) done = 1;
    end
    out_ready = 1'b1;
    exp_frames++;
    checks++;
    if (!done || xfer_count - x0 != 8 || exp_q.size() != 0 || frame_count !== exp_frames[15:0]) begin
      failures++;
      $display("FAIL backpressure_end got done=%0d xfers=%0d left=%0d frames=%0d want 1 8 0 %0d",
               done, xfer_count - x0, exp_q.size(), frame_count, exp_frames);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    fire(mat_sat, 0, 1);
    checks++;
    if (out_data[15:0] !== 16'h7FFF || out_data[31:16] !== 16'h8000 ||
        out_data[47:32] !== 16'h0100 || out_sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_shift0 got %h %h %h sat=%b want 7fff 8000 0100 sat=1",
               out_data[15:0], out_data[31:16], out_data[47:32], out_sat);
    end
    out_ready = 1'b1;
    repeat (8) step();
    exp_frames++;
    checks++;
    if (drain_done !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sat_drain0 got dd=%b valid=%b want 1 0", drain_done, out_valid);
    end

    out_ready = 1'b0;
    fire(mat_sat, 4, 1);
    checks++;
    if (out_data[47:32] !== 16'h0010 || out_data[15:0] !== 16'h1000 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_shift4 got e2=%h e0=%h sat=%b want 0010 1000 sat=0",
               out_data[47:32], out_data[15:0], out_sat);
    end
    out_ready = 1'b1;
    repeat (8) step();
    exp_frames++;

    out_ready = 1'b0;
    fire(mat_sat, 31, 1);
    checks++;
    if (out_data[31:16] !== 16'hFFFF || out_data[15:0] !== 16'h0000 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_shift31 got e1=%h e0=%h sat=%b want ffff 0000 sat=0",
               out_data[31:16], out_data[15:0], out_sat);
    end
    out_ready = 1'b1;
    repeat (8) step();
    exp_frames++;
    checks++;
    if (frame_count !== exp_frames[15:0] || exp_q.size() != 0) begin
      failures++;
      $display("FAIL sat_frames got frames=%0d left=%0d want %0d 0", frame_count, exp_q.size(), exp_frames);
    end
  endtask

  task automatic test_overrun();
    out_ready = 1'b1;
    fire(mat_a, 2, 1);
    repeat (3) step();
    checks++;
    if (out_row !== 3'd3) begin
      failures++;
      $display("FAIL ovr_pos got row=%0d want 3", out_row);
    end
    fire(mat_b, 0, 0);
    checks++;
    if (overrun !== 1'b1 || out_row !== 3'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set got ovr=%b row=%0d busy=%b want 1 4 1", overrun, out_row, busy);
    end
    repeat (4) step();
    exp_frames++;
    checks++;
    if (drain_done !== 1'b1 || overrun !== 1'b1 || frame_count !== exp_frames[15:0] || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ovr_drain got dd=%b ovr=%b frames=%0d left=%0d want 1 1 %0d 0",
               drain_done, overrun, frame_count, exp_q.size(), exp_frames);
    end
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear got %b want 0", overrun);
    end
    // A fresh overrun event in the same cycle as clr_flags must leave the flag set.
    fire(mat_b, 1, 1);
    step();
    clr_flags = 1'b1;
    fire(mat_a, 0, 0);
    clr_flags = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set_wins got %b want 1", overrun);
    end
    repeat (6) step();
    exp_frames++;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    fire(mat_a, 3, 1);
    repeat (7) step();
    checks++;
    if (out_row !== 3'd7 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL b2b_pos got row=%0d last=%b want 7 1", out_row, out_last);
    end
    fire(mat_b, 0, 1);
    exp_frames++;
    checks++;
    if (out_valid !== 1'b1 || out_row !== 3'd0 || drain_done !== 1'b1 || overrun !== 1'b0 ||
        frame_count !== exp_frames[15:0]) begin
      failures++;
      $display("FAIL b2b_join got valid=%b row=%0d dd=%b ovr=%b frames=%0d want 1 0 1 0 %0d",
               out_valid, out_row, drain_done, overrun, frame_count, exp_frames);
    end
    repeat (8) step();
    exp_frames++;
    checks++;
    if (drain_done !== 1'b1 || frame_count !== exp_frames[15:0] || exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got dd=%b frames=%0d left=%0d valid=%b want 1 %0d 0 0",
               drain_done, frame_count, exp_q.size(), out_valid, exp_frames);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    fire(mat_a, 0, 1);
    repeat (4) step();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0 || out_row !== 3'd0) begin
      failures++;
      $display("FAIL reset_async got valid=%b busy=%b frames=%0d row=%0d want 0 0 0 0",
               out_valid, busy, frame_count, out_row);
    end
    exp_q.delete();
    exp_frames = 0;
    step();
    rst = 1'b1;
    step();
    fire(mat_b, 5, 1);
    checks++;
    if (out_valid !== 1'b1 || out_row !== 3'd0) begin
      failures++;
      $display("FAIL reset_recover got valid=%b row=%0d want 1 0", out_valid, out_row);
    end
    repeat (8) step();
    exp_frames++;
    checks++;
    if (frame_count !== exp_frames[15:0] || drain_done !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_recover_end got frames=%0d dd=%b left=%0d want %0d 1 0",
               frame_count, drain_done, exp_q.size(), exp_frames);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    mat_sat = '0;
    for (int i = 0; i < 64; i++) begin
      mat_seq[i*32 +: 32] = 32'(i);
      mat_a[i*32 +: 32]   = $urandom();
      mat_b[i*32 +: 32]   = $urandom_range(0, 200000) - 100000;
    end
    mat_sat[31:0]  = 32'h0001_0000;
    mat_sat[63:32] = 32'hFFFE_0000;
    mat_sat[95:64] = 32'h0000_0100;

    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
